// File: rtl/collision_detector_if.sv
// Bus between the Asteroids pixel pipeline and the collision detector.
// The master drives scan-position pixel flags; the slave returns per-frame results.
interface collision_detector_if #(
    parameter int NUM_ROCKS   = 10,
    parameter int NUM_BULLETS = 4
);
    logic                   frame_start;
    logic                   video_on;
    logic [NUM_ROCKS-1:0]   rock_pixel;
    logic [NUM_BULLETS-1:0] bullet_pixel;
    logic                   ship_pixel;
    logic [NUM_ROCKS-1:0]   rock_reset;
    logic [NUM_BULLETS-1:0] bullet_reset;
    logic                   ship_hit;
    logic [15:0]            score;
    logic [2:0]             lives;
    logic                   invuln;
    logic                   game_over;

    modport master (
        output frame_start, video_on, rock_pixel, bullet_pixel, ship_pixel,
        input  rock_reset, bullet_reset, ship_hit, score, lives, invuln, game_over
    );

    modport slave (
        input  frame_start, video_on, rock_pixel, bullet_pixel, ship_pixel,
        output rock_reset, bullet_reset, ship_hit, score, lives, invuln, game_over
    );
endinterface

// File: rtl/collision_detector.sv
// Accumulates rock/bullet/ship overlaps over a frame and commits them at frame_start.
// Define SCORE_BCD_EN for a 4-digit BCD score saturating at 9999 (default: binary, saturating at FFFF).
module collision_detector #(
    parameter int NUM_ROCKS       = 10,
    parameter int NUM_BULLETS     = 4,
    parameter int LIVES           = 3,
    parameter int COOLDOWN_FRAMES = 120,
    parameter int POINTS          = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    collision_detector_if.slave  bus
);
    typedef enum logic [1:0] {PLAY = 2'd0, COOLDOWN = 2'd1, OVER = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [NUM_ROCKS-1:0]   kill_acc_q, kill_acc_d, rock_acc_q, rock_acc_d;
    logic [NUM_ROCKS-1:0]   rock_reset_q, rock_reset_d;
    logic [NUM_BULLETS-1:0] bul_acc_q, bul_acc_d, bullet_reset_q, bullet_reset_d;
    logic                   ship_acc_q, ship_acc_d, ship_hit_q, ship_hit_d;
    logic                   invuln_q, invuln_d, game_over_q, game_over_d;
    logic [15:0]            score_q, score_d;
    logic [2:0]             lives_q, lives_d;
    logic [7:0]             cnt_q, cnt_d;

    logic                   acc_en_s, play_s, bul_any_s, rock_any_s;
    logic [NUM_ROCKS-1:0]   kill_new_s, rock_new_s;
    logic [NUM_BULLETS-1:0] bul_new_s;
    logic                   ship_new_s;
    logic [31:0]            add_s;
    logic [15:0]            score_sat_s;

    function automatic logic [31:0] popcount(input logic [NUM_ROCKS-1:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < NUM_ROCKS; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

`ifdef SCORE_BCD_EN
    logic [16:0] amt_bcd_s, sum_bcd_s;

    // Binary to 4 BCD digits; bit 16 flags a value above 9999.
    function automatic logic [16:0] to_bcd(input logic [31:0] v);
        logic [31:0] t, q, r;
        logic [15:0] d;
        t = v;
        d = 16'd0;
        for (int k = 0; k < 4; k++) begin
            q = t / 32'd10;
            r = t - q * 32'd10;
            d[4*k +: 4] = r[3:0];
            t = q;
        end
        return {(t != 32'd0), d};
    endfunction

    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  d;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = 16'd0;
        for (int k = 0; k < 4; k++) begin
            d = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'd0, c};
            if (d > 5'd9) begin
                d = d + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*k +: 4] = d[3:0];
        end
        return {c, r};
    endfunction
`else
    logic [31:0] sum_s;
`endif

    // Next-state logic: overlap terms, frame commit, life/cooldown FSM.
    always_comb begin
        play_s     = (state_q == PLAY);
        acc_en_s   = bus.video_on && (state_q != OVER);
        bul_any_s  = |bus.bullet_pixel;
        rock_any_s = |bus.rock_pixel;
        if (acc_en_s) begin
            kill_new_s = bus.rock_pixel & {NUM_ROCKS{bul_any_s}};
            rock_new_s = bus.rock_pixel & {NUM_ROCKS{bul_any_s | (bus.ship_pixel & play_s)}};
            bul_new_s  = bus.bullet_pixel & {NUM_BULLETS{rock_any_s}};
            ship_new_s = bus.ship_pixel & rock_any_s & play_s;
        end else begin
            kill_new_s = {NUM_ROCKS{1'b0}};
            rock_new_s = {NUM_ROCKS{1'b0}};
            bul_new_s  = {NUM_BULLETS{1'b0}};
            ship_new_s = 1'b0;
        end

        add_s = 32'(POINTS) * popcount(kill_acc_q);
`ifdef SCORE_BCD_EN
        amt_bcd_s   = to_bcd(add_s);
        sum_bcd_s   = bcd_add(score_q, amt_bcd_s[15:0]);
        score_sat_s = (amt_bcd_s[16] || sum_bcd_s[16]) ? 16'h9999 : sum_bcd_s[15:0];
`else
        sum_s       = {16'd0, score_q} + add_s;
        score_sat_s = (sum_s > 32'h0000_FFFF) ? 16'hFFFF : sum_s[15:0];
`endif

        state_d        = state_q;
        lives_d        = lives_q;
        cnt_d          = cnt_q;
        score_d        = score_q;
        rock_reset_d   = rock_reset_q;
        bullet_reset_d = bullet_reset_q;
        ship_hit_d     = 1'b0;

        if (bus.frame_start) begin
            // Same-cycle overlaps seed the freshly cleared accumulators.
            kill_acc_d     = kill_new_s;
            rock_acc_d     = rock_new_s;
            bul_acc_d      = bul_new_s;
            ship_acc_d     = ship_new_s;
            rock_reset_d   = rock_acc_q;
            bullet_reset_d = bul_acc_q;
            ship_hit_d     = ship_acc_q;
            if (state_q != OVER) begin
                score_d = score_sat_s;
            end else begin
                score_d = score_q;
            end
            case (state_q)
                PLAY: begin
                    if (ship_acc_q && (lives_q > 3'd1)) begin
                        lives_d = lives_q - 3'd1;
                        cnt_d   = 8'(COOLDOWN_FRAMES);
                        state_d = COOLDOWN;
                    end else if (ship_acc_q) begin
                        lives_d = 3'd0;
                        state_d = OVER;
                    end else begin
                        state_d = PLAY;
                    end
                end
                COOLDOWN: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = PLAY;
                    end else begin
                        state_d = COOLDOWN;
                    end
                end
                OVER:    state_d = OVER;
                default: state_d = PLAY;
            endcase
        end else begin
            kill_acc_d = kill_acc_q | kill_new_s;
            rock_acc_d = rock_acc_q | rock_new_s;
            bul_acc_d  = bul_acc_q | bul_new_s;
            ship_acc_d = ship_acc_q | ship_new_s;
        end

        if (state_d == OVER) begin
            rock_reset_d   = {NUM_ROCKS{1'b1}};
            bullet_reset_d = {NUM_BULLETS{1'b1}};
        end else begin
            rock_reset_d   = rock_reset_d;
            bullet_reset_d = bullet_reset_d;
        end
        invuln_d    = (state_d == COOLDOWN);
        game_over_d = (state_d == OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= PLAY;
            kill_acc_q     <= {NUM_ROCKS{1'b0}};
            rock_acc_q     <= {NUM_ROCKS{1'b0}};
            bul_acc_q      <= {NUM_BULLETS{1'b0}};
            ship_acc_q     <= 1'b0;
            rock_reset_q   <= {NUM_ROCKS{1'b0}};
            bullet_reset_q <= {NUM_BULLETS{1'b0}};
            ship_hit_q     <= 1'b0;
            score_q        <= 16'd0;
            lives_q        <= 3'(LIVES);
            cnt_q          <= 8'd0;
            invuln_q       <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            kill_acc_q     <= kill_acc_d;
            rock_acc_q     <= rock_acc_d;
            bul_acc_q      <= bul_acc_d;
            ship_acc_q     <= ship_acc_d;
            rock_reset_q   <= rock_reset_d;
            bullet_reset_q <= bullet_reset_d;
            ship_hit_q     <= ship_hit_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            cnt_q          <= cnt_d;
            invuln_q       <= invuln_d;
            game_over_q    <= game_over_d;
        end
    end

    assign bus.rock_reset   = rock_reset_q;
    assign bus.bullet_reset = bullet_reset_q;
    assign bus.ship_hit     = ship_hit_q;
    assign bus.score        = score_q;
    assign bus.lives        = lives_q;
    assign bus.invuln       = invuln_q;
    assign bus.game_over    = game_over_q;
endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench: directed game scenarios plus random pixel traffic,
// compared every cycle against a frame-level behavioural model.
module tb_collision_detector;
    localparam int NR = 10;
    localparam int NB = 4;
    localparam int M_PLAY = 0, M_COOL = 1, M_OVER = 2;
`ifdef SCORE_BCD_EN
    localparam int          SCORE_MAX = 9999;
    localparam logic [15:0] SCORE_TOP = 16'h9999;
`else
    localparam int          SCORE_MAX = 65535;
    localparam logic [15:0] SCORE_TOP = 16'hFFFF;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    collision_detector_if #(.NUM_ROCKS(NR), .NUM_BULLETS(NB)) bus ();

    collision_detector #(
        .NUM_ROCKS(NR), .NUM_BULLETS(NB), .LIVES(3), .COOLDOWN_FRAMES(120), .POINTS(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: sets of things touched this frame, plus game bookkeeping.
    bit [NR-1:0] m_kill, m_rock, m_rr;
    bit [NB-1:0] m_bul, m_br;
    bit          m_ship, m_hit;
    int          m_score, m_lives, m_cd, m_mode;

    function automatic logic [15:0] enc(input int v);
`ifdef SCORE_BCD_EN
        return 16'((v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
`else
        return 16'(v);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rst, input logic fs, input logic vo,
                         input logic [NR-1:0] rp, input logic [NB-1:0] bp, input logic sp);
        bit [NR-1:0] nk, nr;
        bit [NB-1:0] nb;
        bit          ns;
        if (rst) begin
            m_kill = '0; m_rock = '0; m_bul = '0; m_ship = 0;
            m_rr = '0; m_br = '0; m_hit = 0;
            m_score = 0; m_lives = 3; m_cd = 0; m_mode = M_PLAY;
            return;
        end
        nk = '0; nr = '0; nb = '0; ns = 0;
        if (vo && m_mode != M_OVER) begin
            for (int i = 0; i < NR; i++) begin
                if (rp[i] && bp != 0) nk[i] = 1;
                if (rp[i] && (bp != 0 || (sp && m_mode == M_PLAY))) nr[i] = 1;
            end
            for (int j = 0; j < NB; j++) begin
                if (bp[j] && rp != 0) nb[j] = 1;
            end
            ns = sp && (rp != 0) && (m_mode == M_PLAY);
        end
        if (fs) begin
            m_rr = m_rock;
            m_br = m_bul;
            m_hit = m_ship;
            if (m_mode != M_OVER) begin
                m_score = m_score + $countones(m_kill);
                if (m_score > SCORE_MAX) m_score = SCORE_MAX;
            end
            if (m_mode == M_PLAY && m_ship) begin
                if (m_lives > 1) begin
                    m_lives--; m_cd = 120; m_mode = M_COOL;
                end else begin
                    m_lives = 0; m_mode = M_OVER;
                end
            end else if (m_mode == M_COOL) begin
                m_cd--;
                if (m_cd == 0) m_mode = M_PLAY;
            end
            m_kill = nk; m_rock = nr; m_bul = nb; m_ship = ns;
        end else begin
            m_hit = 0;
            m_kill |= nk; m_rock |= nr; m_bul |= nb; m_ship |= ns;
        end
        if (m_mode == M_OVER) begin
            m_rr = '1;
            m_br = '1;
        end
    endtask

    task automatic check_all();
        chk("rock_reset", bus.rock_reset, m_rr);
        chk("bullet_reset", bus.bullet_reset, m_br);
        chk("ship_hit", bus.ship_hit, m_hit);
        chk("score", bus.score, enc(m_score));
        chk("lives", bus.lives, m_lives);
        chk("invuln", bus.invuln, m_mode == M_COOL);
        chk("game_over", bus.game_over, m_mode == M_OVER);
    endtask

    task automatic step(input logic fs, input logic vo, input logic [NR-1:0] rp,
                        input logic [NB-1:0] bp, input logic sp, input logic rst = 1'b0);
        @(negedge clk);
        reset            = rst;
        bus.frame_start  = fs;
        bus.video_on     = vo;
        bus.rock_pixel   = rp;
        bus.bullet_pixel = bp;
        bus.ship_pixel   = sp;
        @(posedge clk);
        model(rst, fs, vo, rp, bp, sp);
        #1;
        check_all();
    endtask

    task automatic rand_step(input bit with_ship);
        logic          fs, vo, sp;
        logic [NR-1:0] rp;
        logic [NB-1:0] bp;
        fs = ($urandom_range(0, 15) == 0);
        vo = ($urandom_range(0, 3) != 0);
        rp = NR'($urandom) & NR'($urandom) & NR'($urandom);
        bp = NB'($urandom) & NB'($urandom);
        sp = with_ship && ($urandom_range(0, 63) == 0);
        step(fs, vo, rp, bp, sp);
    endtask

    initial begin
        int frozen;
        reset = 1'b1;
        bus.frame_start = 1'b0; bus.video_on = 1'b0;
        bus.rock_pixel = '0; bus.bullet_pixel = '0; bus.ship_pixel = 1'b0;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_lives", bus.lives, 3'd3);
        chk("rst_score", bus.score, 16'd0);
        chk("rst_rock_reset", bus.rock_reset, 10'h000);

        // Rock 2 and bullet 1 overlap for 5 pixels.
        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 1, 10'h004, 4'h2, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t1_rock_reset", bus.rock_reset, 10'h004);
        chk("t1_bullet_reset", bus.bullet_reset, 4'h2);
        chk("t1_score", bus.score, 16'h0001);
        repeat (4) step(0, 0, 0, 0, 0);
        chk("t1_rock_held", bus.rock_reset, 10'h004);
        step(1, 0, 0, 0, 0);
        chk("t1_rock_clear", bus.rock_reset, 10'h000);
        chk("t1_bullet_clear", bus.bullet_reset, 4'h0);

        // Overlap in the frame_start cycle lands one frame later.
        step(1, 1, 10'h020, 4'h1, 0);
        chk("t6_not_early", bus.rock_reset, 10'h000);
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t6_rock_late", bus.rock_reset, 10'h020);
        chk("t6_bullet_late", bus.bullet_reset, 4'h1);
        chk("t6_score", bus.score, 16'h0002);

        // Ship overlaps rocks 0 and 3.
        repeat (3) step(0, 1, 10'h009, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("t2_ship_hit", bus.ship_hit, 1'b1);
        chk("t2_lives", bus.lives, 3'd2);
        chk("t2_invuln", bus.invuln, 1'b1);
        chk("t2_rock_reset", bus.rock_reset, 10'h009);
        chk("t2_score", bus.score, 16'h0002);
        step(0, 0, 0, 0, 0);
        chk("t2_pulse_end", bus.ship_hit, 1'b0);

        // Ship overlaps a rock every frame of the cooldown.
        for (int f = 1; f <= 120; f++) begin
            step(0, 1, 10'h001, 0, 1);
            step(1, 0, 0, 0, 0);
            if (f == 119) chk("t3_invuln_119", bus.invuln, 1'b1);
        end
        chk("t3_invuln_drop", bus.invuln, 1'b0);
        chk("t3_lives_kept", bus.lives, 3'd2);
        step(0, 1, 10'h001, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("t3_lives_next", bus.lives, 3'd1);

        repeat (3000) rand_step(1'b0);

        // Last life lost.
        for (int k = 0; k < 130 && m_mode != M_PLAY; k++) step(1, 0, 0, 0, 0);
        chk("t4_cooldown_done", bus.invuln, 1'b0);
        step(0, 1, 10'h010, 0, 1);
        step(1, 0, 0, 0, 0);
        frozen = m_score;
        chk("t4_lives", bus.lives, 3'd0);
        chk("t4_game_over", bus.game_over, 1'b1);
        chk("t4_rock_all", bus.rock_reset, 10'h3FF);
        repeat (3) step(0, 1, 10'h3FF, 4'hF, 0);
        step(1, 1, 10'h3FF, 4'hF, 0);
        step(1, 0, 0, 0, 0);
        chk("t4_score_frozen", bus.score, enc(frozen));
        chk("t4_rock_held", bus.rock_reset, 10'h3FF);

        // Mid-frame reset.
        step(0, 1, 10'h001, 4'h1, 1, 1);
        chk("rst2_lives", bus.lives, 3'd3);
        chk("rst2_game_over", bus.game_over, 1'b0);
        chk("rst2_rock_reset", bus.rock_reset, 10'h000);
        chk("rst2_score", bus.score, 16'd0);

        // Ten kills per frame until the score saturates.
        repeat (6560) step(1, 1, 10'h3FF, 4'h1, 0);
        chk("t5_saturated", bus.score, SCORE_TOP);
        step(1, 1, 10'h3FF, 4'h1, 0);
        chk("t5_stays", bus.score, SCORE_TOP);
        step(0, 0, 0, 0, 0, 1);

        repeat (2000) rand_step(1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
